// File: rtl/truth_table_sequencer_pkg.sv
// Shared types and helpers for the truth-table sequencer: FSM encoding and
// table-width derivation.
package truth_table_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int NUM_IN_DEFAULT = 4;
    localparam int SETTLE_DEFAULT = 2;
    // Wide enough for the largest legal settle time (15).
    localparam int SETTLE_CNT_W   = 4;

    function automatic int tw_of(input int num_in);
        return 1 << num_in;
    endfunction

endpackage

// File: rtl/truth_table_sequencer_if.sv
// Control, status and unit-under-test signals of the truth-table sequencer.
interface truth_table_sequencer_if
    import truth_table_sequencer_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEFAULT
) ();

    localparam int TW = tw_of(NUM_IN);

    // start is a level request taken on any cycle the sequencer sits in IDLE;
    // busy=1 means requests are ignored, done is a single-cycle completion pulse.
    logic              start;
    logic              abort;
    logic [TW-1:0]     expected;
    logic              dut_o;
    logic [NUM_IN-1:0] dut_in;
    logic              busy;
    logic              done;
    logic              pass;
    logic [TW-1:0]     truth_table;
    logic [NUM_IN:0]   err_count;
    logic [NUM_IN-1:0] first_err;
    logic              err_valid;
    state_t            state;

    modport slave (
        input  start, abort, expected, dut_o,
        output dut_in, busy, done, pass, truth_table, err_count, first_err,
               err_valid, state
    );

    modport master (
        output start, abort, expected, dut_o,
        input  dut_in, busy, done, pass, truth_table, err_count, first_err,
               err_valid, state
    );

endinterface

// File: rtl/truth_table_sequencer_settle_timer.sv
// Settle counter: cleared by load, advanced by en, flags the last settle cycle.
module settle_timer
    import truth_table_sequencer_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc
);

    logic [SETTLE_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + SETTLE_CNT_W'(1);
        end
    end

    assign tc = (cnt == SETTLE_CNT_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector of a small combinational unit, captures its truth
// table and compares it against an expected table latched at start.
module truth_table_sequencer
    import truth_table_sequencer_pkg::*;
#(
    parameter int NUM_IN = NUM_IN_DEFAULT,
    parameter int SETTLE = SETTLE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    truth_table_sequencer_if.slave bus
);

    localparam int TW = tw_of(NUM_IN);
    localparam int CW = NUM_IN + 1;

    state_t            state, state_next;
    logic [NUM_IN-1:0] idx;
    logic [NUM_IN-1:0] dut_in_r;
    logic [TW-1:0]     exp_latch;
    logic [TW-1:0]     table_r;
    logic [CW-1:0]     err_count_r;
    logic [NUM_IN-1:0] first_err_r;
    logic              err_valid_r;
    logic              busy_r;
    logic              done_r;
    logic              pass_r;

    logic timer_load;
    logic timer_en;
    logic settle_tc;
    logic last;
    logic mismatch;

    assign last     = (idx == NUM_IN'(TW - 1));
    assign mismatch = (bus.dut_o != exp_latch[idx]);

    settle_timer #(.SETTLE(SETTLE)) u_settle_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load),
        .en    (timer_en),
        .tc    (settle_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_SETTLE;
                    timer_load = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (settle_tc) begin
                    state_next = ST_SAMPLE;
                end else begin
                    timer_en = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (bus.abort) begin
                    state_next = ST_IDLE;
                end else if (last) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_SETTLE;
                    timer_load = 1'b1;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Results stay frozen outside a sweep so software can read them after done
    // or after an abort; only dut_in and the status flags react to abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            dut_in_r    <= '0;
            exp_latch   <= '0;
            table_r     <= '0;
            err_count_r <= '0;
            first_err_r <= '0;
            err_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        exp_latch   <= bus.expected;
                        table_r     <= '0;
                        err_count_r <= '0;
                        first_err_r <= '0;
                        err_valid_r <= 1'b0;
                        pass_r      <= 1'b0;
                        idx         <= '0;
                        dut_in_r    <= '0;
                        busy_r      <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (bus.abort) begin
                        busy_r   <= 1'b0;
                        pass_r   <= 1'b0;
                        dut_in_r <= '0;
                    end
                end
                ST_SAMPLE: begin
                    if (bus.abort) begin
                        busy_r   <= 1'b0;
                        pass_r   <= 1'b0;
                        dut_in_r <= '0;
                    end else begin
                        table_r[idx] <= bus.dut_o;
                        if (mismatch) begin
                            err_count_r <= err_count_r + CW'(1);
                            if (!err_valid_r) begin
                                first_err_r <= idx;
                                err_valid_r <= 1'b1;
                            end
                        end
                        if (!last) begin
                            idx      <= idx + NUM_IN'(1);
                            dut_in_r <= idx + NUM_IN'(1);
                        end
                    end
                end
                ST_DONE: begin
                    busy_r <= 1'b0;
                    if (bus.abort) begin
                        pass_r   <= 1'b0;
                        dut_in_r <= '0;
                    end else begin
                        done_r <= 1'b1;
                        pass_r <= (err_count_r == '0);
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dut_in      = dut_in_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.pass        = pass_r;
    assign bus.truth_table = table_r;
    assign bus.err_count   = err_count_r;
    assign bus.first_err   = first_err_r;
    assign bus.err_valid   = err_valid_r;
    assign bus.state       = state;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed bench for truth_table_sequencer with NUM_IN=4, SETTLE=2 and a
// behavioural unit o = a&b | c&d (or o stuck at 0).
module tb_truth_table_sequencer;

    logic clk;
    logic rst_n;
    int   model_sel;
    int   tests;
    int   fails;

    truth_table_sequencer_if #(.NUM_IN(4)) bus ();

    truth_table_sequencer #(.NUM_IN(4), .SETTLE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Unit under test: a = dut_in[3], d = dut_in[0].
    assign bus.dut_o = (model_sel == 0) ?
        ((bus.dut_in[3] & bus.dut_in[2]) | (bus.dut_in[1] & bus.dut_in[0])) : 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_dut_in"},    32'(bus.dut_in), 0);
        check({tag, "_busy"},      32'(bus.busy), 0);
        check({tag, "_done"},      32'(bus.done), 0);
        check({tag, "_pass"},      32'(bus.pass), 0);
        check({tag, "_table"},     32'(bus.truth_table), 0);
        check({tag, "_err_count"}, 32'(bus.err_count), 0);
        check({tag, "_first_err"}, 32'(bus.first_err), 0);
        check({tag, "_err_valid"}, 32'(bus.err_valid), 0);
        check({tag, "_state"},     32'(bus.state), 0);
    endtask

    // Starts a sweep and watches 60 cycles after the acceptance edge (n=0).
    // dut_in must equal n/3 for n=1..47; done_cycle is the n where done rose.
    task automatic run_sweep(input logic [15:0] exp, input int hold_until,
                             input logic with_abort, output int done_cycle,
                             output int done_pulses);
        @(negedge clk);
        bus.expected = exp;
        bus.start    = 1'b1;
        bus.abort    = with_abort;
        @(negedge clk);
        bus.abort = 1'b0;
        if (hold_until == 0) bus.start = 1'b0;
        check("accept_busy", 32'(bus.busy), 1);
        check("accept_dut_in", 32'(bus.dut_in), 0);
        bus.expected = ~exp;
        done_cycle  = -1;
        done_pulses = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == hold_until) bus.start = 1'b0;
            if (n <= 47) check("dut_in_seq", 32'(bus.dut_in), 32'(n / 3));
            if (bus.done) begin
                done_pulses++;
                if (done_cycle < 0) done_cycle = n;
            end
        end
    endtask

    initial begin
        int dc;
        int dp;
        int found;
        tests     = 0;
        fails     = 0;
        model_sel = 0;
        rst_n     = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.expected = '0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Correct unit, matching expected table.
        run_sweep(16'hF888, 0, 1'b0, dc, dp);
        check("t1_done_cycle", 32'(dc), 49);
        check("t1_done_pulses", 32'(dp), 1);
        check("t1_table", 32'(bus.truth_table), 32'h0000F888);
        check("t1_pass", 32'(bus.pass), 1);
        check("t1_err_count", 32'(bus.err_count), 0);
        check("t1_err_valid", 32'(bus.err_valid), 0);
        check("t1_busy", 32'(bus.busy), 0);

        // One-bit difference at index 0; start held high through the sweep.
        run_sweep(16'hF889, 48, 1'b0, dc, dp);
        check("t2_done_cycle", 32'(dc), 49);
        check("t2_done_pulses", 32'(dp), 1);
        check("t2_busy", 32'(bus.busy), 0);
        check("t2_pass", 32'(bus.pass), 0);
        check("t2_err_count", 32'(bus.err_count), 1);
        check("t2_first_err", 32'(bus.first_err), 0);
        check("t2_err_valid", 32'(bus.err_valid), 1);
        check("t2_table", 32'(bus.truth_table), 32'h0000F888);

        // Stuck-at-0 unit against all-ones: maximum mismatch count.
        model_sel = 1;
        run_sweep(16'hFFFF, 0, 1'b0, dc, dp);
        check("t3_done_cycle", 32'(dc), 49);
        check("t3_err_count", 32'(bus.err_count), 16);
        check("t3_first_err", 32'(bus.first_err), 0);
        check("t3_err_valid", 32'(bus.err_valid), 1);
        check("t3_table", 32'(bus.truth_table), 0);
        check("t3_pass", 32'(bus.pass), 0);
        model_sel = 0;

        // Abort while vector 5 is settling.
        @(negedge clk);
        bus.expected = 16'hF888;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        found = 0;
        for (int n = 1; n <= 30; n++) begin
            if (bus.dut_in == 4'd5) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        check("t4_reached_idx5", 32'(found), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("t4_busy", 32'(bus.busy), 0);
        check("t4_dut_in", 32'(bus.dut_in), 0);
        check("t4_done", 32'(bus.done), 0);
        check("t4_pass", 32'(bus.pass), 0);
        check("t4_state", 32'(bus.state), 0);
        check("t4_table_partial", 32'(bus.truth_table), 32'h00000008);
        check("t4_err_count", 32'(bus.err_count), 0);
        dp = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.done) dp++;
        end
        check("t4_no_done", 32'(dp), 0);

        // Restart with abort also high in IDLE: start wins, sweep passes.
        run_sweep(16'hF888, 0, 1'b1, dc, dp);
        check("t4r_done_cycle", 32'(dc), 49);
        check("t4r_pass", 32'(bus.pass), 1);
        check("t4r_table", 32'(bus.truth_table), 32'h0000F888);

        // Asynchronous reset in the middle of a settle window.
        @(negedge clk);
        bus.expected = 16'hF889;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_busy_before", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("t5_reset");
        dp = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (n == 0) rst_n = 1'b1;
            if (bus.done) dp++;
        end
        check("t5_no_done", 32'(dp), 0);
        check("t5_idle_busy", 32'(bus.busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
